// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the ping-pong frame-buffer controller.
package frame_buf_pkg;

  localparam int FRAME_PIXELS_DEF = 256;
  localparam int RD_LAT_DEF       = 1;
  localparam int FCNT_W_DEF       = 16;

  typedef logic bank_t;

  function automatic int cnt_w(input int pixels);
    return $clog2(pixels);
  endfunction

  function automatic int addr_w(input int pixels);
    return $clog2(pixels) + 1;
  endfunction

endpackage

// File: rtl/frame_buf_rdpipe.sv
// Read-data tracking pipe: valid and last tags delayed by the BRAM latency.
module frame_buf_rdpipe
  import frame_buf_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [RD_LAT-1:0] v_q;
  logic [RD_LAT-1:0] l_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      l_q <= '0;
    end else if (clear) begin
      v_q <= '0;
      l_q <= '0;
    end else begin
      v_q[0] <= in_valid;
      l_q[0] <= in_valid & in_last;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign out_valid = v_q[RD_LAT-1];
  assign out_last  = l_q[RD_LAT-1];

endmodule

// File: rtl/frame_buf_ctrl.sv
// Ping-pong frame-buffer controller: concurrent fill and drain of two
// BRAM banks with full tracking, completion pulses and overrun counting.
module frame_buf_ctrl
  import frame_buf_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int RD_LAT       = RD_LAT_DEF,
  parameter int FCNT_W       = FCNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          soft_clear,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          ena,
  output logic [cnt_w(FRAME_PIXELS):0]  addra,
  input  logic                          rd_ready,
  output logic                          enb,
  output logic [cnt_w(FRAME_PIXELS):0]  addrb,
  output logic                          rd_valid,
  output logic                          rd_last,
  output logic                          complete,
  output logic [FCNT_W-1:0]             frames_done,
  output logic [FCNT_W-1:0]             drop_cnt,
  output logic                          overrun
);

  localparam int CNT_W = cnt_w(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(FRAME_PIXELS - 1);

  bank_t            wr_bank;
  bank_t            rd_bank;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_issued;

  logic wr_last;
  logic rd_armed;
  logic rd_tag;
  logic pipe_valid;
  logic pipe_last;
  logic release_bank;
  logic drop;

  // A bank only opens for a new frame while start is high;
  // a frame already under way runs to completion regardless.
  assign wr_ready = !soft_clear
                  && !full[wr_bank]
                  && (wr_cnt != '0 || start);
  assign ena      = wr_valid & wr_ready;
  assign wr_last  = ena && (wr_cnt == LAST_IDX);
  assign drop     = wr_valid & !wr_ready;

  assign rd_armed = !soft_clear
                  && full[rd_bank]
                  && !rd_issued
                  && (rd_cnt != '0 || start);
  assign enb      = rd_armed & rd_ready;
  assign rd_tag   = (rd_cnt == LAST_IDX);

  assign addra = {wr_bank, wr_cnt};
  assign addrb = {rd_bank, rd_cnt};

  frame_buf_rdpipe #(
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (soft_clear),
    .in_valid  (enb),
    .in_last   (rd_tag),
    .out_valid (pipe_valid),
    .out_last  (pipe_last)
  );

  // The bank is handed back only once its last pixel leaves the BRAM.
  assign release_bank = pipe_valid & pipe_last;
  assign rd_valid     = pipe_valid;
  assign rd_last      = pipe_last;
  assign complete     = release_bank;

  // Fill and release always target different banks, so both apply.
  always_comb begin
    full_nxt = full;
    if (wr_last)
      full_nxt[wr_bank] = 1'b1;
    if (release_bank)
      full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      rd_issued   <= 1'b0;
      frames_done <= '0;
      drop_cnt    <= '0;
      overrun     <= 1'b0;
    end else if (soft_clear) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      rd_issued   <= 1'b0;
      frames_done <= '0;
      drop_cnt    <= '0;
      overrun     <= 1'b0;
    end else begin
      full <= full_nxt;

      if (ena) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
        if (wr_last)
          wr_bank <= ~wr_bank;
      end

      if (enb) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
        if (rd_tag)
          rd_issued <= 1'b1;
      end

      if (release_bank) begin
        rd_bank     <= ~rd_bank;
        rd_issued   <= 1'b0;
        frames_done <= frames_done + FCNT_W'(1);
      end

      if (drop) begin
        overrun <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed bench for frame_buf_ctrl: one DUT at RD_LAT=1, one at RD_LAT=3,
// both driven by the same stimulus.
module tb_frame_buf_ctrl;

  logic clk;
  logic reset_n;
  logic start;
  logic soft_clear;
  logic wr_valid;
  logic rd_ready;

  logic        wr_ready_1, ena_1, enb_1;
  logic [8:0]  addra_1, addrb_1;
  logic        rd_valid_1, rd_last_1, complete_1;
  logic [15:0] frames_done_1, drop_cnt_1;
  logic        overrun_1;

  logic        wr_ready_3, ena_3, enb_3;
  logic [8:0]  addra_3, addrb_3;
  logic        rd_valid_3, rd_last_3, complete_3;
  logic [15:0] frames_done_3, drop_cnt_3;
  logic        overrun_3;

  int n_cmp;
  int n_err;

  frame_buf_ctrl #(
    .FRAME_PIXELS (256),
    .RD_LAT       (1),
    .FCNT_W       (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .soft_clear  (soft_clear),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready_1),
    .ena         (ena_1),
    .addra       (addra_1),
    .rd_ready    (rd_ready),
    .enb         (enb_1),
    .addrb       (addrb_1),
    .rd_valid    (rd_valid_1),
    .rd_last     (rd_last_1),
    .complete    (complete_1),
    .frames_done (frames_done_1),
    .drop_cnt    (drop_cnt_1),
    .overrun     (overrun_1)
  );

  frame_buf_ctrl #(
    .FRAME_PIXELS (256),
    .RD_LAT       (3),
    .FCNT_W       (16)
  ) dut3 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .soft_clear  (soft_clear),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready_3),
    .ena         (ena_3),
    .addra       (addra_3),
    .rd_ready    (rd_ready),
    .enb         (enb_3),
    .addrb       (addrb_3),
    .rd_valid    (rd_valid_3),
    .rd_last     (rd_last_3),
    .complete    (complete_3),
    .frames_done (frames_done_3),
    .drop_cnt    (drop_cnt_3),
    .overrun     (overrun_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_clear();
    @(negedge clk);
    soft_clear = 1'b1;
    start      = 1'b0;
    wr_valid   = 1'b0;
    rd_ready   = 1'b0;
    @(negedge clk);
    soft_clear = 1'b0;
  endtask

  task automatic fill_bank0();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      start    = 1'b1;
      wr_valid = 1'b1;
      rd_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [47:0] got;
    logic [47:0] exp;
    reset_n    = 1'b0;
    start      = 1'b0;
    soft_clear = 1'b0;
    wr_valid   = 1'b0;
    rd_ready   = 1'b0;
    @(negedge clk);
    #1;
    got = {wr_ready_1, ena_1, enb_1, addra_1, addrb_1,
           rd_valid_1, rd_last_1, complete_1, overrun_1,
           rd_valid_3, 3'b000};
    exp = '0;
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_ctl: got %h want %h", got, exp);
    end
    n_cmp++;
    if (frames_done_1 !== 16'd0 || drop_cnt_1 !== 16'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got fd=%0d dc=%0d want 0 0",
               frames_done_1, drop_cnt_1);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [12:0] got;
    logic [12:0] exp;
    do_clear();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      start    = 1'b1;
      rd_ready = 1'b1;
      wr_valid = 1'b1;
      #1;
      n_cmp++;
      if ({ena_1, enb_1, addra_1} !== {1'b1, 1'b0, 9'(i)}) begin
        n_err++;
        $display("FAIL fill_wr[%0d]: got ena=%b enb=%b a=%h want 1 0 %h",
                 i, ena_1, enb_1, addra_1, 9'(i));
      end
    end
    for (int k = 0; k <= 256; k++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      got = {enb_1, addrb_1, rd_valid_1, rd_last_1, complete_1};
      exp = {(k < 256), (k < 256) ? 9'(k) : 9'd0,
             (k >= 1), (k == 256), (k == 256)};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL drain[%0d]: got %h want %h", k, got, exp);
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({frames_done_1, enb_1, rd_valid_1} !== {16'd1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL drain_done: got fd=%0d enb=%b rv=%b want 1 0 0",
               frames_done_1, enb_1, rd_valid_1);
    end
  endtask

  task automatic test_ping_pong();
    int acc;
    int cyc;
    do_clear();
    acc = 0;
    cyc = 0;
    while (!(acc == 768 && frames_done_1 == 16'd3) && cyc < 2500) begin
      @(negedge clk);
      start    = 1'b1;
      rd_ready = 1'b1;
      #1;
      wr_valid = (acc < 768) && wr_ready_1;
      #1;
      if (wr_valid) begin
        n_cmp++;
        if (addra_1 !== 9'(acc)) begin
          n_err++;
          $display("FAIL pp_addra[%0d]: got %h want %h",
                   acc, addra_1, 9'(acc));
        end
        acc++;
      end
      if (ena_1 && enb_1) begin
        n_cmp++;
        if (addra_1[8] === addrb_1[8]) begin
          n_err++;
          $display("FAIL pp_bank: got a=%h b=%h want distinct banks",
                   addra_1, addrb_1);
        end
      end
      cyc++;
    end
    wr_valid = 1'b0;
    n_cmp++;
    if (acc != 768 || frames_done_1 !== 16'd3) begin
      n_err++;
      $display("FAIL pp_frames: got acc=%0d fd=%0d want 768 3",
               acc, frames_done_1);
    end
    n_cmp++;
    if (drop_cnt_1 !== 16'd0 || overrun_1 !== 1'b0) begin
      n_err++;
      $display("FAIL pp_drops: got dc=%0d ov=%b want 0 0",
               drop_cnt_1, overrun_1);
    end
  endtask

  task automatic test_overrun();
    do_clear();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start    = 1'b1;
      rd_ready = 1'b0;
      wr_valid = 1'b1;
      #1;
      n_cmp++;
      if (wr_ready_1 !== (i < 512)) begin
        n_err++;
        $display("FAIL ovr_ready[%0d]: got %b want %b",
                 i, wr_ready_1, (i < 512));
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    n_cmp++;
    if ({drop_cnt_1, overrun_1, enb_1} !== {16'd88, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL ovr_cnt: got dc=%0d ov=%b enb=%b want 88 1 0",
               drop_cnt_1, overrun_1, enb_1);
    end
    for (int k = 0; k <= 257; k++) begin
      @(negedge clk);
      rd_ready = 1'b1;
      #1;
      if (k == 0) begin
        n_cmp++;
        if ({enb_1, addrb_1} !== {1'b1, 9'h000}) begin
          n_err++;
          $display("FAIL ovr_first: got enb=%b b=%h want 1 000",
                   enb_1, addrb_1);
        end
      end
      if (k == 257) begin
        n_cmp++;
        if ({enb_1, addrb_1, frames_done_1, overrun_1, drop_cnt_1}
            !== {1'b1, 9'h100, 16'd1, 1'b1, 16'd88}) begin
          n_err++;
          $display("FAIL ovr_second: got enb=%b b=%h fd=%0d ov=%b dc=%0d want 1 100 1 1 88",
                   enb_1, addrb_1, frames_done_1, overrun_1, drop_cnt_1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int iss;
    int ncomp;
    logic exp_enb;
    logic [2:0] hv;
    logic [2:0] hl;
    do_clear();
    fill_bank0();
    iss   = 0;
    ncomp = 0;
    hv    = '0;
    hl    = '0;
    for (int k = 0; k < 560; k++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      start    = 1'b1;
      rd_ready = (k % 2 == 0);
      #1;
      exp_enb = rd_ready && (iss < 256);
      n_cmp++;
      if (enb_3 !== exp_enb) begin
        n_err++;
        $display("FAIL bp_enb[%0d]: got %b want %b", k, enb_3, exp_enb);
      end
      if (iss < 256) begin
        n_cmp++;
        if (addrb_3 !== 9'(iss)) begin
          n_err++;
          $display("FAIL bp_addrb[%0d]: got %h want %h",
                   k, addrb_3, 9'(iss));
        end
      end
      n_cmp++;
      if ({rd_valid_3, rd_last_3} !== {hv[2], hl[2]}) begin
        n_err++;
        $display("FAIL bp_rv[%0d]: got v=%b l=%b want %b %b",
                 k, rd_valid_3, rd_last_3, hv[2], hl[2]);
      end
      if (complete_3)
        ncomp++;
      hv = {hv[1:0], exp_enb};
      hl = {hl[1:0], exp_enb && (iss == 255)};
      if (exp_enb)
        iss++;
    end
    n_cmp++;
    if (ncomp != 1 || frames_done_3 !== 16'd1) begin
      n_err++;
      $display("FAIL bp_complete: got n=%0d fd=%0d want 1 1",
               ncomp, frames_done_3);
    end
  endtask

  task automatic test_start_gating();
    do_clear();
    for (int i = 0; i < 266; i++) begin
      @(negedge clk);
      start    = (i < 100);
      wr_valid = 1'b1;
      rd_ready = 1'b1;
      #1;
      n_cmp++;
      if ({wr_ready_1, ena_1} !== {(i < 256), (i < 256)}) begin
        n_err++;
        $display("FAIL sg_ready[%0d]: got rdy=%b ena=%b want %b",
                 i, wr_ready_1, ena_1, (i < 256));
      end
      if (i < 256) begin
        n_cmp++;
        if (addra_1 !== 9'(i)) begin
          n_err++;
          $display("FAIL sg_addra[%0d]: got %h want %h",
                   i, addra_1, 9'(i));
        end
      end else begin
        n_cmp++;
        if (enb_1 !== 1'b0) begin
          n_err++;
          $display("FAIL sg_rd_gate[%0d]: got enb=%b want 0", i, enb_1);
        end
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    n_cmp++;
    if ({drop_cnt_1, overrun_1} !== {16'd10, 1'b1}) begin
      n_err++;
      $display("FAIL sg_drops: got dc=%0d ov=%b want 10 1",
               drop_cnt_1, overrun_1);
    end
  endtask

  task automatic test_mid_reset(input bit use_async);
    logic [31:0] got;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start    = 1'b0;
      wr_valid = 1'b1;
    end
    fill_bank0();
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      start    = 1'b1;
      #1;
    end
    n_cmp++;
    if ({addrb_1, rd_valid_1, drop_cnt_1} !== {9'd50, 1'b1, 16'd3}) begin
      n_err++;
      $display("FAIL mr_pre(%0d): got b=%h rv=%b dc=%0d want 032 1 3",
               use_async, addrb_1, rd_valid_1, drop_cnt_1);
    end
    if (use_async) begin
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({rd_valid_1, rd_valid_3, addrb_1} !== {1'b0, 1'b0, 9'd0}) begin
        n_err++;
        $display("FAIL mr_async_now: got rv=%b rv3=%b b=%h want 0 0 000",
                 rd_valid_1, rd_valid_3, addrb_1);
      end
    end else begin
      soft_clear = 1'b1;
    end
    @(negedge clk);
    soft_clear = 1'b0;
    reset_n    = 1'b1;
    #1;
    got = {enb_1, ena_1, addra_1, addrb_1, rd_valid_1, rd_last_1,
           complete_1, overrun_1, rd_valid_3, enb_3, 6'd0};
    n_cmp++;
    if (got !== 32'd0) begin
      n_err++;
      $display("FAIL mr_ctl(%0d): got %h want 0", use_async, got);
    end
    n_cmp++;
    if ({frames_done_1, drop_cnt_1} !== 32'd0) begin
      n_err++;
      $display("FAIL mr_cnt(%0d): got fd=%0d dc=%0d want 0 0",
               use_async, frames_done_1, drop_cnt_1);
    end
    @(negedge clk);
    wr_valid = 1'b1;
    #1;
    n_cmp++;
    if ({wr_ready_1, ena_1, addra_1} !== {1'b1, 1'b1, 9'h000}) begin
      n_err++;
      $display("FAIL mr_resume(%0d): got rdy=%b ena=%b a=%h want 1 1 000",
               use_async, wr_ready_1, ena_1, addra_1);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill_drain();
    test_ping_pong();
    test_overrun();
    test_backpressure();
    test_start_gating();
    test_mid_reset(1'b0);
    test_mid_reset(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
